// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared types and constants for the PC / instruction-fetch sequencer.
//   fetch_state_e : sequencer states (IDLE, FETCH, VALID, FAULT)
//   fault_cause_e : encoding reported on fault_cause
//   NOP_INSTR     : instruction presented before the first fetch completes
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    VALID = 2'b10,
    FAULT = 2'b11
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    MISALIGN = 2'b01,
    TIMEOUT  = 2'b10
  } fault_cause_e;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr
//   Counts consecutive FETCH cycles that did not receive instruction data.
//   Parameters:
//     LIMIT     : number of data-less FETCH cycles tolerated
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     clear_i   : force the count back to zero (held while not fetching)
//     enable_i  : advance the count by one this cycle
//     expired_o : the current cycle is the LIMIT-th data-less cycle
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // The count holds how many earlier FETCH cycles went by without data, so
  // the final tolerated cycle is the one where the count already equals
  // LIMIT-1. Clearing wins over enabling so every FETCH entry starts at zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + W'(1);
    end
  end

  // Plain count register; reset puts it back to zero along with the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Holds the architectural PC and runs a single-outstanding request/valid
//   fetch handshake to instruction memory. Traps misaligned next-PC values
//   and, when PC_FETCH_TIMEOUT_EN is defined, fetches that never return.
//   Parameters:
//     RESET_PC      : PC after reset (word aligned)
//     FETCH_TIMEOUT : FETCH cycles allowed before a timeout fault
//                     (only used with PC_FETCH_TIMEOUT_EN)
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     next_pc, stall             : next PC from PC select, core hold request
//     imem_req, imem_addr        : fetch request and address (= pc_out)
//     imem_rvalid, imem_rdata    : returned instruction
//     instr_out, instr_valid     : held instruction and its validity
//     pc_out, pc_plus4_out       : current PC and PC+4 (wrapping)
//     fetch_fault, fault_cause   : sticky fault flag and its cause
//   Configuration macro: PC_FETCH_TIMEOUT_EN
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  if (RESET_PC[1:0] != 2'b00) begin : gBadResetPc
    $error("pc_fetch_unit: RESET_PC must be word aligned");
  end

  if (FETCH_TIMEOUT < 1) begin : gBadTimeout
    $error("pc_fetch_unit: FETCH_TIMEOUT must be at least 1");
  end

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  instr_q;
  logic [31:0]  instr_d;
  fault_cause_e cause_q;
  fault_cause_e cause_d;
  logic         timeoutHit;

`ifdef PC_FETCH_TIMEOUT_EN
  logic ctrExpired;

  // The counter sits at zero whenever we are not fetching, which gives the
  // "clear on FETCH entry" behaviour without needing an entry pulse.
  fetch_timeout_ctr #(
    .LIMIT (FETCH_TIMEOUT)
  ) uTimeoutCtr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q != FETCH),
    .enable_i  ((state_q == FETCH) && !imem_rvalid),
    .expired_o (ctrExpired)
  );

  assign timeoutHit = ctrExpired;
`else
  assign timeoutHit = 1'b0;
`endif

  // State register. Reset is asynchronous so an in-flight request drops the
  // moment rst_n falls, and anything memory returns afterwards is ignored
  // because only FETCH ever looks at imem_rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Returned data beats a timeout in the same cycle, and a
  // misaligned next_pc sends us to FAULT instead of issuing a bad fetch.
  // FAULT only leaves through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_rvalid) begin
          state_d = VALID;
        end else if (timeoutHit) begin
          state_d = FAULT;
        end
      end
      VALID: begin
        if (!stall) begin
          state_d = (next_pc[1:0] == 2'b00) ? FETCH : FAULT;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Every control output is a pure function of the state so
  // nothing from the inputs leaks combinationally to the outputs.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
    case (state_q)
      FETCH:   imem_req    = 1'b1;
      VALID:   instr_valid = 1'b1;
      FAULT:   fetch_fault = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values. The PC loads next_pc on the same edge that leaves
  // VALID, so the first FETCH cycle already drives the new address. A
  // misaligned target is still loaded so it can be inspected while faulted.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cause_d = cause_q;
    case (state_q)
      FETCH: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
        end else if (timeoutHit) begin
          cause_d = TIMEOUT;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            cause_d = MISALIGN;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers: PC, held instruction and fault cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      cause_q <= NONE;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cause_q <= cause_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_q + 32'd4;
  assign instr_out    = instr_q;
  assign fault_cause  = cause_q;

endmodule
